// File: rtl/aes_ram_resp_pkg.sv
// Shared definitions for the AES RAM responder: address map, register bit
// positions, FSM encoding and the mask LFSR polynomial.
package aes_ram_resp_pkg;

    localparam int ADR_W     = 9;
    localparam int DAT_W     = 32;
    localparam int RAM_AW    = 8;
    localparam int RAM_DEPTH = 256;

    localparam logic [ADR_W-1:0] RAM_TOP    = 9'h0FF;
    localparam logic [ADR_W-1:0] CTRL_ADR   = 9'h100;
    localparam logic [ADR_W-1:0] STATUS_ADR = 9'h101;

    localparam int CTRL_IR_LSB   = 0;
    localparam int CTRL_LEN_LSB  = 2;
    localparam int CTRL_MODE_LSB = 4;
    localparam int CTRL_GO       = 7;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TO   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } aes_state_t;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/aes_mask_lfsr.sv
// Free-running 32-bit Galois LFSR producing the AES datapath mask word.
// Advances every cycle; loads SEED under reset (SEED must be nonzero).
module aes_mask_lfsr
    import aes_ram_resp_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1D2C_3B4A
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Mask
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Mask <= SEED;
        end else begin
            Mask <= lfsrNext(Mask);
        end
    end

endmodule

// File: rtl/aes_ram_resp.sv
// Host/AES shared 256x32 RAM with CTRL/STATUS registers and AES sequencing FSM.
// Host reads return one cycle later; host RAM access stalls while the AES core runs.
module aes_ram_resp
    import aes_ram_resp_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h1D2C_3B4A,
    parameter logic [15:0] SEQ_TO    = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              HostRd,
    input  logic              HostWr,
    input  logic [ADR_W-1:0]  HostAdr,
    input  logic [DAT_W-1:0]  HostWDat,
    output logic              HostReady,
    output logic [DAT_W-1:0]  HostRDat,
    output logic              HostRdValid,
    output logic              AesIrq,
    output logic              StartAes,
    output logic [1:0]        AesIR,
    output logic [1:0]        AesLen,
    output logic [2:0]        AesMode,
    input  logic              AesRamRd,
    input  logic              AesRamWr,
    input  logic [RAM_AW-1:0] AesRamAdr,
    input  logic [DAT_W-1:0]  AesRamDat,
    output logic [DAT_W-1:0]  RamAesDat,
    output logic [DAT_W-1:0]  MaskIn,
    input  logic              AesDone
);

    logic [DAT_W-1:0] mem [RAM_DEPTH];

    aes_state_t state, stateNxt;
    logic [6:0]  ctrl;
    logic        done;
    logic        timeOut;
    logic [15:0] busyCnt;

    logic             hostReq;
    logic             hostIsRam;
    logic             fsmBusy;
    logic             hostWrAcc;
    logic             hostRdAcc;
    logic             ctrlWr;
    logic             statWr;
    logic             goReq;
    logic             doneHit;
    logic             toHit;
    logic [DAT_W-1:0] statusWord;
    logic [DAT_W-1:0] hostRdWord;

    assign hostReq   = HostRd | HostWr;
    assign hostIsRam = (HostAdr <= RAM_TOP);
    assign fsmBusy   = (state != ST_IDLE);

    // Only RAM traffic collides with the running AES core; registers stay reachable.
    assign HostReady = hostReq && !(hostIsRam && fsmBusy);
    assign hostWrAcc = HostWr && HostReady;
    assign hostRdAcc = HostRd && !HostWr && HostReady;

    assign ctrlWr  = hostWrAcc && (HostAdr == CTRL_ADR);
    assign statWr  = hostWrAcc && (HostAdr == STATUS_ADR);
    assign goReq   = ctrlWr && HostWDat[CTRL_GO] && (state == ST_IDLE);
    assign doneHit = (state == ST_BUSY) && AesDone;
    // A completion arriving on the timeout cycle counts as a normal finish.
    assign toHit   = (state == ST_BUSY) && !AesDone && (busyCnt == SEQ_TO - 16'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE:  if (goReq) stateNxt = ST_START;
            ST_START: stateNxt = ST_BUSY;
            ST_BUSY:  if (doneHit || toHit) stateNxt = ST_IDLE;
            default:  stateNxt = ST_IDLE;
        endcase
    end

    assign StartAes = (state == ST_START);
    assign AesIR    = ctrl[CTRL_IR_LSB   +: 2];
    assign AesLen   = ctrl[CTRL_LEN_LSB  +: 2];
    assign AesMode  = ctrl[CTRL_MODE_LSB +: 3];
    assign AesIrq   = done;

    // Go is never stored, so it reads back as zero; fields freeze outside IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ctrl    <= '0;
            done    <= 1'b0;
            timeOut <= 1'b0;
            busyCnt <= '0;
        end else begin
            if (ctrlWr && (state == ST_IDLE)) begin
                ctrl <= HostWDat[6:0];
            end

            if ((state == ST_BUSY) && (stateNxt == ST_BUSY)) begin
                busyCnt <= busyCnt + 16'd1;
            end else begin
                busyCnt <= '0;
            end

            if (doneHit || toHit) begin
                done <= 1'b1;
            end else if (statWr && HostWDat[STAT_DONE]) begin
                done <= 1'b0;
            end

            if (toHit) begin
                timeOut <= 1'b1;
            end else if (statWr && HostWDat[STAT_TO]) begin
                timeOut <= 1'b0;
            end
        end
    end

    always_comb begin
        statusWord            = '0;
        statusWord[STAT_BUSY] = fsmBusy;
        statusWord[STAT_DONE] = done;
        statusWord[STAT_TO]   = timeOut;
    end

    always_comb begin
        hostRdWord = '0;
        if (hostIsRam) begin
            hostRdWord = mem[HostAdr[RAM_AW-1:0]];
        end else if (HostAdr == CTRL_ADR) begin
            hostRdWord = {25'b0, ctrl};
        end else if (HostAdr == STATUS_ADR) begin
            hostRdWord = statusWord;
        end
    end

    // Contents are deliberately not reset. The AES write comes last so it wins
    // if both sides hit the same word in one cycle.
    always_ff @(posedge Clk) begin
        if (hostWrAcc && hostIsRam) begin
            mem[HostAdr[RAM_AW-1:0]] <= HostWDat;
        end
        if (AesRamWr) begin
            mem[AesRamAdr] <= AesRamDat;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            HostRdValid <= 1'b0;
            HostRDat    <= '0;
            RamAesDat   <= '0;
        end else begin
            HostRdValid <= hostRdAcc;
            if (hostRdAcc) begin
                HostRDat <= hostRdWord;
            end
            if (AesRamRd) begin
                RamAesDat <= mem[AesRamAdr];
            end
        end
    end

    aes_mask_lfsr #(
        .SEED (LFSR_SEED)
    ) uMaskLfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .Mask  (MaskIn)
    );

endmodule

// File: tb/tb_aes_ram_resp.sv
// Bench for aes_ram_resp: register/RAM vector table, AES sequencing corner
// cases, and randomized RAM traffic against an array model plus LFSR model.
module tb_aes_ram_resp;

    localparam logic [31:0] SEED  = 32'h1D2C_3B4A;
    localparam logic [15:0] TO    = 16'd16;
    localparam logic [8:0]  CTRLA = 9'h100;
    localparam logic [8:0]  STATA = 9'h101;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        HostRd, HostWr;
    logic [8:0]  HostAdr;
    logic [31:0] HostWDat;
    logic        HostReady;
    logic [31:0] HostRDat;
    logic        HostRdValid;
    logic        AesIrq, StartAes;
    logic [1:0]  AesIR, AesLen;
    logic [2:0]  AesMode;
    logic        AesRamRd, AesRamWr;
    logic [7:0]  AesRamAdr;
    logic [31:0] AesRamDat;
    logic [31:0] RamAesDat;
    logic [31:0] MaskIn;
    logic        AesDone;

    aes_ram_resp #(.LFSR_SEED(SEED), .SEQ_TO(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .HostRd(HostRd), .HostWr(HostWr), .HostAdr(HostAdr), .HostWDat(HostWDat),
        .HostReady(HostReady), .HostRDat(HostRDat), .HostRdValid(HostRdValid),
        .AesIrq(AesIrq), .StartAes(StartAes),
        .AesIR(AesIR), .AesLen(AesLen), .AesMode(AesMode),
        .AesRamRd(AesRamRd), .AesRamWr(AesRamWr), .AesRamAdr(AesRamAdr),
        .AesRamDat(AesRamDat), .RamAesDat(RamAesDat), .MaskIn(MaskIn),
        .AesDone(AesDone)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] maskM;
    logic [31:0] mdl [256];

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [8:0]  adr;
        logic [31:0] wdat;
        logic        expRdy;
        logic        expVld;
        logic [31:0] expDat;
    } vec_t;

    vec_t vecs[9];

    // Mask model: polynomial from its exponent list, stepped by division by x.
    function automatic logic [31:0] galoisStep(input logic [31:0] s);
        int exps[4];
        logic [31:0] taps;
        exps = '{32, 22, 2, 1};
        taps = '0;
        foreach (exps[i]) taps[exps[i]-1] = 1'b1;
        return (s >> 1) ^ (s[0] ? taps : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset) maskM = SEED;
        else       maskM = galoisStep(maskM);
        #2;
    endtask

    task automatic hostWrite(input logic [8:0] a, input logic [31:0] d);
        HostWr = 1'b1; HostAdr = a; HostWDat = d;
        step();
        HostWr = 1'b0;
        if (a <= 9'h0FF) mdl[a[7:0]] = d;
    endtask

    task automatic hostRead(input logic [8:0] a, output logic [31:0] d, output logic v);
        HostRd = 1'b1; HostAdr = a;
        step();
        HostRd = 1'b0;
        d = HostRDat;
        v = HostRdValid;
    endtask

    task automatic aesRead(input logic [7:0] a);
        AesRamRd = 1'b1; AesRamAdr = a;
        step();
        AesRamRd = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        int          n;

        Reset = 1'b1; HostRd = 0; HostWr = 0; HostAdr = '0; HostWDat = '0;
        AesRamRd = 0; AesRamWr = 0; AesRamAdr = '0; AesRamDat = '0; AesDone = 0;
        maskM = SEED;
        repeat (3) step();

        chk("rst_start",   {31'b0, StartAes},    32'h0);
        chk("rst_rdvalid", {31'b0, HostRdValid}, 32'h0);
        chk("rst_rdat",    HostRDat,             32'h0);
        chk("rst_ramaes",  RamAesDat,            32'h0);
        chk("rst_mask",    MaskIn,               SEED);
        chk("rst_irq",     {31'b0, AesIrq},      32'h0);
        Reset = 1'b0;

        vecs[0] = '{"wr_ram10",   0, 1, 9'h010, 32'hA5A5_0001, 1, 0, 32'h0};
        vecs[1] = '{"rd_ram10",   1, 0, 9'h010, 32'h0,         1, 1, 32'hA5A5_0001};
        vecs[2] = '{"rd_status0", 1, 0, STATA,  32'h0,         1, 1, 32'h0};
        vecs[3] = '{"wr_ctrl35",  0, 1, CTRLA,  32'h0000_0035, 1, 0, 32'h0};
        vecs[4] = '{"rd_ctrl35",  1, 0, CTRLA,  32'h0,         1, 1, 32'h35};
        vecs[5] = '{"wr_ctrl0",   0, 1, CTRLA,  32'h0,         1, 0, 32'h0};
        vecs[6] = '{"rdwr_ram11", 1, 1, 9'h011, 32'h1234_5678, 1, 0, 32'h0};
        vecs[7] = '{"rd_ram11",   1, 0, 9'h011, 32'h0,         1, 1, 32'h1234_5678};
        vecs[8] = '{"rd_unmap",   1, 0, 9'h150, 32'h0,         1, 1, 32'h0};

        for (int i = 0; i < 9; i++) begin
            HostRd = vecs[i].rd; HostWr = vecs[i].wr;
            HostAdr = vecs[i].adr; HostWDat = vecs[i].wdat;
            #1;
            chk({vecs[i].name, "_rdy"}, {31'b0, HostReady}, {31'b0, vecs[i].expRdy});
            step();
            HostRd = 1'b0; HostWr = 1'b0;
            chk({vecs[i].name, "_vld"}, {31'b0, HostRdValid}, {31'b0, vecs[i].expVld});
            if (vecs[i].expVld) chk({vecs[i].name, "_dat"}, HostRDat, vecs[i].expDat);
        end
        mdl[8'h10] = 32'hA5A5_0001;
        mdl[8'h11] = 32'h1234_5678;

        aesRead(8'h10);
        chk("aes_rd10", RamAesDat, 32'hA5A5_0001);

        hostWrite(9'h020, 32'h1111_1111);
        AesRamRd = 1; AesRamWr = 1; AesRamAdr = 8'h20; AesRamDat = 32'h2222_2222;
        step();
        AesRamRd = 0; AesRamWr = 0;
        chk("aes_rdwr_old", RamAesDat, 32'h1111_1111);
        aesRead(8'h20);
        chk("aes_rd_new", RamAesDat, 32'h2222_2222);
        mdl[8'h20] = 32'h2222_2222;

        AesDone = 1; step(); AesDone = 0;
        chk("done_idle_ign", {31'b0, AesIrq}, 32'h0);

        hostWrite(CTRLA, 32'h85);
        chk("go_start", {31'b0, StartAes}, 32'h1);
        chk("go_fields", {25'b0, AesMode, AesLen, AesIR}, 32'h05);
        hostRead(STATA, d, v);
        chk("busy_status", d, 32'h1);
        chk("start_pulse", {31'b0, StartAes}, 32'h0);

        HostRd = 1; HostAdr = 9'h010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", {31'b0, HostReady}, 32'h0);
            step();
        end
        AesDone = 1; step(); AesDone = 0;
        #1;
        chk("stall_release", {31'b0, HostReady}, 32'h1);
        chk("irq_set", {31'b0, AesIrq}, 32'h1);
        step();
        HostRd = 0;
        chk("stall_rd_vld", {31'b0, HostRdValid}, 32'h1);
        chk("stall_rd_dat", HostRDat, 32'hA5A5_0001);
        hostRead(CTRLA, d, v);
        chk("ctrl_go_clr", d, 32'h05);
        hostWrite(STATA, 32'h2);
        chk("irq_w1c", {31'b0, AesIrq}, 32'h0);

        hostWrite(CTRLA, 32'h80);
        chk("to_start", {31'b0, StartAes}, 32'h1);
        n = 0;
        while (!AesIrq && n < 100) begin step(); n++; end
        chk("to_cycles", n, 17);
        hostRead(STATA, d, v);
        chk("to_status", d, 32'h6);
        hostWrite(STATA, 32'h6);
        hostRead(STATA, d, v);
        chk("to_w1c", d, 32'h0);

        hostWrite(9'h030, 32'hCAFE_F00D);
        hostWrite(CTRLA, 32'h80);
        step(); step();
        HostWr = 1; HostAdr = CTRLA; HostWDat = 32'h8F;
        #1;
        chk("ctrl_busy_rdy", {31'b0, HostReady}, 32'h1);
        step();
        HostWr = 0;
        chk("ctrl_busy_ign", {30'b0, AesIR}, 32'h0);
        aesRead(8'h30);
        chk("aes_rd_busy", RamAesDat, 32'hCAFE_F00D);
        Reset = 1; step();
        chk("mid_rst_start", {31'b0, StartAes}, 32'h0);
        chk("mid_rst_mask",  MaskIn, SEED);
        chk("mid_rst_irq",   {31'b0, AesIrq}, 32'h0);
        chk("mid_rst_ramaes", RamAesDat, 32'h0);
        Reset = 0;
        hostRead(STATA, d, v);
        chk("mid_rst_status", d, 32'h0);
        hostRead(9'h030, d, v);
        chk("mid_rst_ram", d, 32'hCAFE_F00D);

        for (int a = 8'h40; a < 8'h50; a++) hostWrite({1'b0, a[7:0]}, $urandom);
        for (int it = 0; it < 150; it++) begin
            logic [7:0]  a1, a2;
            logic [31:0] d1, d2;
            a1 = 8'h40 + 8'($urandom_range(0, 15));
            a2 = 8'h40 + 8'($urandom_range(0, 15));
            d1 = $urandom; d2 = $urandom;
            case ($urandom_range(0, 4))
                0: hostWrite({1'b0, a1}, d1);
                1: begin
                    AesRamWr = 1; AesRamAdr = a1; AesRamDat = d1;
                    step();
                    AesRamWr = 0;
                    mdl[a1] = d1;
                end
                2: begin
                    hostRead({1'b0, a1}, d, v);
                    chk("rnd_host_rd", d, mdl[a1]);
                end
                3: begin
                    aesRead(a1);
                    chk("rnd_aes_rd", RamAesDat, mdl[a1]);
                end
                default: begin
                    if (a1 == a2) a2 = a1 ^ 8'h01;
                    HostWr = 1; HostAdr = {1'b0, a1}; HostWDat = d1;
                    AesRamWr = 1; AesRamAdr = a2; AesRamDat = d2;
                    step();
                    HostWr = 0; AesRamWr = 0;
                    mdl[a1] = d1; mdl[a2] = d2;
                end
            endcase
            chk("rnd_mask", MaskIn, maskM);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
